// File: rtl/margin_topk_select.sv
// Streaming top-K smallest-margin selector: keeps the K most uncertain samples of a round and drains them
// in ascending-margin order. Optional index cross-check against the accepted count under MARGIN_IDX_CHECK_EN.
module margin_topk_select #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 16,
    parameter int K          = 8,
    parameter int N_SAMPLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  cnt_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_margin,
    input  logic [IDX_WIDTH-1:0]  in_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic [DATA_WIDTH-1:0] out_margin,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  idx_err
);
    localparam int PTR_W  = (K > 1) ? $clog2(K) : 1;
    localparam int N_KEEP = (K < N_SAMPLES) ? K : N_SAMPLES;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(N_KEEP - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_CNT = IDX_WIDTH'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  idx_err_q, idx_err_d;
    logic [DATA_WIDTH-1:0] slot_margin_q [K];
    logic [DATA_WIDTH-1:0] slot_margin_d [K];
    logic [IDX_WIDTH-1:0]  slot_idx_q [K];
    logic [IDX_WIDTH-1:0]  slot_idx_d [K];
    logic [K-1:0]          slot_vld_q, slot_vld_d;

    logic [K-1:0]          gt_s;
    logic [DATA_WIDTH-1:0] ins_margin_s [K];
    logic [IDX_WIDTH-1:0]  ins_idx_s [K];
    logic [K-1:0]          ins_vld_s;
    logic                  drain_s;

    // Sorted-insert network: gt_s is a thermometer since valid slots are contiguous and ascending
    always_comb begin
        for (int i = 0; i < K; i++) begin
            gt_s[i] = !slot_vld_q[i] || (slot_margin_q[i] > in_margin);
        end
        if (gt_s[0]) begin
            ins_margin_s[0] = in_margin;
            ins_idx_s[0]    = in_idx;
            ins_vld_s[0]    = 1'b1;
        end else begin
            ins_margin_s[0] = slot_margin_q[0];
            ins_idx_s[0]    = slot_idx_q[0];
            ins_vld_s[0]    = slot_vld_q[0];
        end
        for (int i = 1; i < K; i++) begin
            if (!gt_s[i]) begin
                ins_margin_s[i] = slot_margin_q[i];
                ins_idx_s[i]    = slot_idx_q[i];
                ins_vld_s[i]    = slot_vld_q[i];
            end else if (!gt_s[i-1]) begin
                ins_margin_s[i] = in_margin;
                ins_idx_s[i]    = in_idx;
                ins_vld_s[i]    = 1'b1;
            end else begin
                ins_margin_s[i] = slot_margin_q[i-1];
                ins_idx_s[i]    = slot_idx_q[i-1];
                ins_vld_s[i]    = slot_vld_q[i-1];
            end
        end
    end

    // Next-state logic for the round FSM, accept counter, slot array and read pointer
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_ptr_d      = rd_ptr_q;
        idx_err_d     = idx_err_q;
        slot_margin_d = slot_margin_q;
        slot_idx_d    = slot_idx_q;
        slot_vld_d    = slot_vld_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_COLLECT;
                    cnt_d      = '0;
                    rd_ptr_d   = '0;
                    idx_err_d  = 1'b0;
                    slot_vld_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    cnt_d         = cnt_q + IDX_WIDTH'(1);
                    slot_margin_d = ins_margin_s;
                    slot_idx_d    = ins_idx_s;
                    slot_vld_d    = ins_vld_s;
`ifdef MARGIN_IDX_CHECK_EN
                    if (in_idx != cnt_q) begin
                        idx_err_d = 1'b1;
                    end else begin
                        idx_err_d = idx_err_q;
                    end
`endif
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifndef MARGIN_IDX_CHECK_EN
    logic unused_idx_s;
    assign unused_idx_s = ^in_idx;
`endif

    // All block state, synchronously reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            idx_err_q  <= 1'b0;
            slot_vld_q <= '0;
            for (int i = 0; i < K; i++) begin
                slot_margin_q[i] <= '0;
                slot_idx_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            idx_err_q     <= idx_err_d;
            slot_vld_q    <= slot_vld_d;
            slot_margin_q <= slot_margin_d;
            slot_idx_q    <= slot_idx_d;
        end
    end

    assign drain_s    = (state_q == S_DRAIN);
    assign cnt_en     = (state_q == S_COLLECT);
    assign in_ready   = (state_q == S_COLLECT);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = drain_s;
    assign out_idx    = drain_s ? slot_idx_q[rd_ptr_q] : '0;
    assign out_margin = drain_s ? slot_margin_q[rd_ptr_q] : '0;
    assign out_last   = drain_s && (rd_ptr_q == LAST_PTR);
    assign done       = drain_s && out_ready && (rd_ptr_q == LAST_PTR);
    assign idx_err    = idx_err_q;
endmodule

// File: tb/tb_margin_topk_select.sv
// Scoreboard bench for margin_topk_select: a K=8/N=1024 instance and a K=8/N=3 instance.
module tb_margin_topk_select;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

`ifdef MARGIN_IDX_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        a_start, a_cnt_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_out_last, a_busy, a_done, a_idx_err;
    logic [15:0] a_in_margin, a_in_idx, a_out_idx, a_out_margin;
    logic        b_start, b_cnt_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_out_last, b_busy, b_done, b_idx_err;
    logic [15:0] b_in_margin, b_in_idx, b_out_idx, b_out_margin;

    margin_topk_select #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(8), .N_SAMPLES(1024)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .cnt_en(a_cnt_en),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_margin(a_in_margin), .in_idx(a_in_idx),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_margin(a_out_margin), .out_last(a_out_last), .busy(a_busy), .done(a_done),
        .idx_err(a_idx_err));

    margin_topk_select #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(8), .N_SAMPLES(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .cnt_en(b_cnt_en),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_margin(b_in_margin), .in_idx(b_in_idx),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_margin(b_out_margin), .out_last(b_out_last), .busy(b_busy), .done(b_done),
        .idx_err(b_idx_err));

    typedef struct packed {
        logic [15:0] idx;
        logic [15:0] margin;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic a_bp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Downstream ready for instance A: constant high, or toggling every cycle when a_bp is set
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = a_bp ? ~a_out_ready : 1'b1;
        end
    end

    // Monitor A: pops scoreboard on handshake, checks hold-stability under backpressure and done
    initial begin
        exp_t        e;
        logic        hold_v;
        logic [15:0] hold_idx, hold_m;
        hold_v = 1'b0;
        hold_idx = 16'd0;
        hold_m = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("a_hold_valid", a_out_valid, 1);
                    chk("a_hold_idx", a_out_idx, hold_idx);
                    chk("a_hold_margin", a_out_margin, hold_m);
                end
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) begin
                        fail_now("a_unexpected_output");
                    end else begin
                        e = qa.pop_front();
                        chk("a_out_idx", a_out_idx, e.idx);
                        chk("a_out_margin", a_out_margin, e.margin);
                        chk("a_out_last", a_out_last, e.last);
                        chk("a_done", a_done, e.last);
                    end
                end else if (a_done) begin
                    fail_now("a_done_without_final_handshake");
                end
                hold_v   = a_out_valid && !a_out_ready;
                hold_idx = a_out_idx;
                hold_m   = a_out_margin;
            end
        end
    end

    // Monitor B: pops scoreboard on handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b_out_valid && b_out_ready) begin
                    if (qb.size() == 0) begin
                        fail_now("b_unexpected_output");
                    end else begin
                        e = qb.pop_front();
                        chk("b_out_idx", b_out_idx, e.idx);
                        chk("b_out_margin", b_out_margin, e.margin);
                        chk("b_out_last", b_out_last, e.last);
                        chk("b_done", b_done, e.last);
                    end
                end else if (b_done) begin
                    fail_now("b_done_without_final_handshake");
                end
            end
        end
    end

    task automatic a_start_round();
        @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
    endtask

    task automatic push_a(input int idx, input int margin, input logic last);
        exp_t e;
        e.idx = 16'(idx);
        e.margin = 16'(margin);
        e.last = last;
        qa.push_back(e);
    endtask

    task automatic push_b(input int idx, input int margin, input logic last);
        exp_t e;
        e.idx = 16'(idx);
        e.margin = 16'(margin);
        e.last = last;
        qb.push_back(e);
    endtask

    task automatic wait_drained(input string name, input logic use_b);
        int left;
        left = use_b ? qb.size() : qa.size();
        for (int c = 0; c < 200 && left != 0; c++) begin
            @(posedge clk);
            left = use_b ? qb.size() : qa.size();
        end
        if (left != 0) begin
            fail_now(name);
            if (use_b) qb.delete();
            else qa.delete();
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, "_busy_after"}, use_b ? b_busy : a_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_in_valid = 1'b0; a_in_margin = 16'd0; a_in_idx = 16'd0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_margin = 16'd0; b_in_idx = 16'd0;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_cnt_en", a_cnt_en, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_done", a_done, 0);
        chk("rst_idx_err", a_idx_err, 0);

        // Abort a round with a 2-cycle reset mid-collect
        a_start_round();
        for (int k = 0; k < 10; k++) begin
            a_in_valid = 1'b1; a_in_margin = 16'(100 - k); a_in_idx = 16'(k);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        chk("mid_busy", a_busy, 1);
        chk("mid_cnt_en", a_cnt_en, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", a_busy, 0);
        chk("abort_cnt_en", a_cnt_en, 0);
        chk("abort_in_ready", a_in_ready, 0);
        chk("abort_out_valid", a_out_valid, 0);
        chk("abort_done", a_done, 0);

        // Ascending margins with an index skip 5->7
        a_start_round();
        for (int j = 0; j < 8; j++) push_a((j < 6) ? j : j + 1, j, j == 7);
        for (int k = 0; k < 1024; k++) begin
            a_in_valid = 1'b1; a_in_margin = 16'(k); a_in_idx = 16'((k < 6) ? k : k + 1);
            @(posedge clk);
            #1;
            if (k == 5) chk("idx_err_before_skip", a_idx_err, 0);
            if (k == 6) chk("idx_err_after_skip", a_idx_err, EXP_ERR);
        end
        a_in_valid = 1'b0;
        chk("skip_first_valid_latency", a_out_valid, 1);
        chk("idx_err_sticky", a_idx_err, EXP_ERR);
        wait_drained("skip_round", 1'b0);
        chk("idx_err_idle", a_idx_err, EXP_ERR);

        // Descending margins: margin = 1023 - idx
        a_start_round();
        chk("idx_err_cleared_by_start", a_idx_err, 0);
        for (int j = 0; j < 8; j++) push_a(1023 - j, j, j == 7);
        for (int k = 0; k < 1024; k++) begin
            a_in_valid = 1'b1; a_in_margin = 16'(1023 - k); a_in_idx = 16'(k);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        chk("desc_first_valid_latency", a_out_valid, 1);
        chk("desc_in_ready_drain", a_in_ready, 0);
        chk("desc_cnt_en_drain", a_cnt_en, 0);
        wait_drained("desc_round", 1'b0);

        // All-equal margins with downstream backpressure
        a_start_round();
        for (int j = 0; j < 8; j++) push_a(j, 5, j == 7);
        for (int k = 0; k < 1024; k++) begin
            a_in_valid = 1'b1; a_in_margin = 16'd5; a_in_idx = 16'(k);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        a_bp = 1'b1;
        wait_drained("ties_bp_round", 1'b0);
        a_bp = 1'b0;

        // Short round N=3 on instance B
        @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        push_b(1, 2, 1'b0);
        push_b(2, 5, 1'b0);
        push_b(0, 9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1'b1;
            b_in_margin = (k == 0) ? 16'd9 : ((k == 1) ? 16'd2 : 16'd5);
            b_in_idx = 16'(k);
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        chk("b_first_valid_latency", b_out_valid, 1);
        chk("b_in_ready_drain", b_in_ready, 0);
        wait_drained("b_round", 1'b1);
        chk("b_idx_err", b_idx_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
